plab4_net_router_adaptive_output_credit_ctrl: RTL and testbench

//  Output-side control for one router output port: arbitrates among per-input

---
 rtl/plab4_net_router_adaptive_output_credit_ctrl.sv | 110 +++++++++++
 tb/tb_plab4_net_router_adaptive_output_credit_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_adaptive_output_credit_ctrl.sv
//------------------------------------------------------------------------------
// plab4_net_router_adaptive_output_credit_ctrl
//
// Output-side control for a single router output port. It arbitrates round
// robin among the per-input route requests, issues a one-hot grant in the same
// cycle, and owns the credit counter for the downstream input queue. num_free
// is exported so the input route logic can make adaptive route choices.
//
// Build option:
//   ROUTER_OUT_CREDIT_BYPASS_EN  when defined, a credit returned while the
//                                counter is empty may be spent in that same
//                                cycle. When undefined, a returned credit is
//                                usable only from the next cycle.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   reqs           request from input i on bit i
//   grants         one-hot grant, combinational from reqs/ptr/num_free
//   sel            crossbar select, binary index of the granted input (0 if none)
//   out_val        a flit leaves this cycle (= |grants)
//   credit_return  downstream freed one queue entry
//   num_free       credits currently available (registered)
//   credit_err     sticky flag: a credit was returned while the counter was full
//------------------------------------------------------------------------------
module plab4_net_router_adaptive_output_credit_ctrl #(
    parameter int p_num_inputs     = 3,
    parameter int p_num_credits    = 2,
    parameter int p_num_free_nbits = 2,
    parameter int p_sel_nbits      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [p_num_inputs-1:0]     reqs,
    output logic [p_num_inputs-1:0]     grants,
    output logic [p_sel_nbits-1:0]      sel,
    output logic                        out_val,
    input  logic                        credit_return,
    output logic [p_num_free_nbits-1:0] num_free,
    output logic                        credit_err
);

    localparam logic [p_num_free_nbits-1:0] c_full     = p_num_free_nbits'(p_num_credits);
    localparam logic [p_num_free_nbits-1:0] c_one      = p_num_free_nbits'(1);
    localparam logic [p_sel_nbits-1:0]      c_last_idx = p_sel_nbits'(p_num_inputs - 1);

    logic [p_sel_nbits-1:0] ptr;
    logic [p_sel_nbits-1:0] ptr_next;
    logic [p_sel_nbits-1:0] cand;
    logic                   eligible;
    logic                   found;
    int                     sum;

`ifdef ROUTER_OUT_CREDIT_BYPASS_EN
    // An incoming return can fund a send even when the counter reads zero.
    assign eligible = (num_free != '0) || credit_return;
`else
    assign eligible = (num_free != '0);
`endif

    // Round-robin scan starting at ptr, wrapping past the last input.
    always_comb begin
        grants = '0;
        sel    = '0;
        found  = 1'b0;
        sum    = 0;
        cand   = '0;
        if (!reset && eligible) begin
            for (int i = 0; i < p_num_inputs; i++) begin
                sum = int'(ptr) + i;
                if (sum >= p_num_inputs) begin
                    sum = sum - p_num_inputs;
                end
                cand = p_sel_nbits'(sum);
                if (!found && reqs[cand]) begin
                    found        = 1'b1;
                    grants[cand] = 1'b1;
                    sel          = cand;
                end
            end
        end
        out_val = found;
    end

    // Priority moves to the input just after the winner.
    assign ptr_next = (sel == c_last_idx) ? '0 : sel + p_sel_nbits'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            num_free   <= c_full;
            credit_err <= 1'b0;
        end else begin
            if (out_val) begin
                ptr <= ptr_next;
            end
            // Send and return together leave the count unchanged.
            if (out_val && !credit_return) begin
                num_free <= num_free - c_one;
            end else if (!out_val && credit_return) begin
                if (num_free == c_full) begin
                    credit_err <= 1'b1;
                end else begin
                    num_free <= num_free + c_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_plab4_net_router_adaptive_output_credit_ctrl.sv
module tb_plab4_net_router_adaptive_output_credit_ctrl;

    localparam int N = 3;
    localparam int C = 2;

`ifdef ROUTER_OUT_CREDIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] reqs;
    logic [N-1:0] grants;
    logic [1:0]   sel;
    logic         out_val;
    logic         credit_return;
    logic [1:0]   num_free;
    logic         credit_err;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_nf;
    int m_ptr;
    bit m_err;

    plab4_net_router_adaptive_output_credit_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .reqs          (reqs),
        .grants        (grants),
        .sel           (sel),
        .out_val       (out_val),
        .credit_return (credit_return),
        .num_free      (num_free),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [2:0] reqs;
        bit         cr;
        logic [2:0] g;
        int         sel;
        bit         ov;
        int         nf;
        bit         err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, logic [2:0] r, bit cr, logic [2:0] g,
                                int s, bit ov, int nf, bit err);
        vec_t v;
        v.rst = rst; v.reqs = r; v.cr = cr; v.g = g;
        v.sel = s; v.ov = ov; v.nf = nf; v.err = err;
        return v;
    endfunction

    // Async reset pulse; outputs must be quiet while reset is high even with
    // requests and returns present.
    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        reqs          = 3'b111;
        credit_return = 1'b1;
        #1;
        chk("rst_grants", int'(grants), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_out_val", int'(out_val), 0);
        chk("rst_num_free", int'(num_free), C);
        chk("rst_credit_err", int'(credit_err), 0);
        @(negedge clk);
        reset         = 1'b0;
        reqs          = '0;
        credit_return = 1'b0;
        m_nf  = C;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // Model: winner is the requester at the smallest forward distance from ptr.
    task automatic model_step(input logic [2:0] r, input bit cr,
                              output int exp_g, output int exp_sel, output int exp_ov);
        int w;
        int best;
        int d;
        w    = -1;
        best = N;
        if (m_nf != 0 || (BYPASS && cr)) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    d = (i - m_ptr + N) % N;
                    if (d < best) begin
                        best = d;
                        w    = i;
                    end
                end
            end
        end
        exp_g   = (w >= 0) ? (1 << w) : 0;
        exp_sel = (w >= 0) ? w : 0;
        exp_ov  = (w >= 0) ? 1 : 0;
        if (w >= 0) m_ptr = (w + 1) % N;
        m_nf = m_nf - exp_ov + (cr ? 1 : 0);
        if (m_nf > C) begin
            m_nf  = C;
            m_err = 1'b1;
        end
    endtask

    initial begin
        int eg, es, eo;
        logic [2:0] r;
        bit cr;

        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        reqs          = '0;
        credit_return = 1'b0;

        // rst, reqs, cr | grants, sel, out_val | num_free after edge, credit_err after edge
        vecs.push_back(mk(0, 3'b001, 0, 3'b001, 0, 1, 1, 0));
        vecs.push_back(mk(0, 3'b001, 0, 3'b001, 0, 1, 0, 0));
        vecs.push_back(mk(0, 3'b001, 0, 3'b000, 0, 0, 0, 0));
`ifdef ROUTER_OUT_CREDIT_BYPASS_EN
        vecs.push_back(mk(0, 3'b010, 1, 3'b010, 1, 1, 0, 0));
`else
        vecs.push_back(mk(0, 3'b010, 1, 3'b000, 0, 0, 1, 0));
`endif
        vecs.push_back(mk(1, 3'b111, 1, 3'b001, 0, 1, 2, 0));
        vecs.push_back(mk(0, 3'b111, 1, 3'b010, 1, 1, 2, 0));
        vecs.push_back(mk(0, 3'b111, 1, 3'b100, 2, 1, 2, 0));
        vecs.push_back(mk(0, 3'b111, 1, 3'b001, 0, 1, 2, 0));
        vecs.push_back(mk(0, 3'b001, 0, 3'b001, 0, 1, 1, 0));
        vecs.push_back(mk(0, 3'b100, 1, 3'b100, 2, 1, 1, 0));
        vecs.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, 2, 0));
        vecs.push_back(mk(0, 3'b000, 1, 3'b000, 0, 0, 2, 1));
        vecs.push_back(mk(0, 3'b001, 0, 3'b001, 0, 1, 1, 1));
        vecs.push_back(mk(1, 3'b000, 0, 3'b000, 0, 0, 2, 0));

        do_reset();

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            @(negedge clk);
            reqs          = vecs[k].reqs;
            credit_return = vecs[k].cr;
            #1;
            chk($sformatf("vec%0d_grants", k), int'(grants), int'(vecs[k].g));
            chk($sformatf("vec%0d_sel", k), int'(sel), vecs[k].sel);
            chk($sformatf("vec%0d_out_val", k), int'(out_val), int'(vecs[k].ov));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_num_free", k), int'(num_free), vecs[k].nf);
            chk($sformatf("vec%0d_credit_err", k), int'(credit_err), int'(vecs[k].err));
        end

        // Sticky error survives further traffic but clears on reset.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reqs          = 3'b000;
            credit_return = (k == 0);
            @(posedge clk);
            #1;
            chk($sformatf("sticky%0d_credit_err", k), int'(credit_err), 1);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            r  = 3'($urandom_range(0, 7));
            cr = ($urandom_range(0, 99) < 45);
            reqs          = r;
            credit_return = cr;
            model_step(r, cr, eg, es, eo);
            #1;
            chk("rand_grants", int'(grants), eg);
            chk("rand_sel", int'(sel), es);
            chk("rand_out_val", int'(out_val), eo);
            @(posedge clk);
            #1;
            chk("rand_num_free", int'(num_free), m_nf);
            chk("rand_credit_err", int'(credit_err), int'(m_err));
            if ((k % 97) == 96) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
